pwm_multi: RTL and testbench

//  Multi-channel PWM generator for the motor-control path; successor to the single-channel pwm.
//  N_CH outputs share one period counter with a programmable prescaler and edge- or center-aligned mode.

---
 rtl/pwm_multi.sv | 184 ++++++++++++++++++
 tb/tb_pwm_multi.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared period counter.
//
// All N_CH channels compare a common counter against their own duty value. The counter
// advances on prescaler ticks and runs either edge-aligned (0..P, wrap) or center-aligned
// (0..P up, P-1..1 down). Period, mode and duties are double-buffered: load captures them
// into pending registers, and they become active only at a period boundary.
//
// Ports
//   clk           system clock
//   clr           synchronous active-high reset, priority over everything
//   en            run enable; low holds the counter at 0 and forces out low
//   prescale      counter advances once every prescale+1 cycles (used live)
//   period        top count P (captured on load)
//   center        0 = edge-aligned, 1 = center-aligned (captured on load)
//   duty          packed duties, channel i at duty[i*W +: W] (captured on load)
//   load          one-cycle strobe capturing period/center/duty as pending
//   load_ack      one-cycle pulse when pending values become active
//   period_start  one-cycle pulse at the start of every PWM period
//   out           PWM outputs (registered)
module pwm_multi #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned PS_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [PS_W-1:0]   prescale,
  input  logic [W-1:0]      period,
  input  logic              center,
  input  logic [N_CH*W-1:0] duty,
  input  logic              load,
  output logic              load_ack,
  output logic              period_start,
  output logic [N_CH-1:0]   out
);

  logic [PS_W-1:0]   presc_q, presc_d;
  logic [W-1:0]      cnt_q, cnt_d;
  logic              dir_q, dir_d;  // 0 = counting up, 1 = counting down

  logic [W-1:0]      act_period_q, act_period_d;
  logic              act_center_q, act_center_d;
  logic [N_CH*W-1:0] act_duty_q, act_duty_d;

  logic [W-1:0]      pend_period_q, pend_period_d;
  logic              pend_center_q, pend_center_d;
  logic [N_CH*W-1:0] pend_duty_q, pend_duty_d;
  logic              pend_flag_q, pend_flag_d;

  // Set in the cycle where cnt has just (re)entered 0 at the start of a period; also held
  // while stopped so the first enabled cycle counts as a period start.
  logic              at_start_q, at_start_d;

  logic              load_ack_q, load_ack_d;
  logic              period_start_q, period_start_d;
  logic [N_CH-1:0]   out_q, out_d;

  logic              tick;
  logic              wrap;
  logic              commit;

  // Prescaler and counter.
  always_comb begin
    tick    = en && (presc_q == prescale);
    presc_d = (!en || tick) ? '0 : presc_q + 1'b1;

    cnt_d = cnt_q;
    dir_d = dir_q;
    wrap  = 1'b0;

    if (!en) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (tick) begin
      if (!act_center_q || (act_period_q == '0)) begin
        // Edge-aligned; center mode with P=0 degenerates to this as well.
        if (cnt_q >= act_period_q) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (!dir_q) begin
        if (cnt_q >= act_period_q) begin
          if (act_period_q == W'(1)) begin
            // P=1 has no down phase: 0,1,0,...
            cnt_d = '0;
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
            dir_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q <= W'(1)) begin
          cnt_d = '0;
          dir_d = 1'b0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  // Double buffering. Pending values commit at a boundary, or right away while stopped.
  // A load in the commit cycle refills pending after the old contents have moved across.
  always_comb begin
    commit = pend_flag_q && (en ? wrap : 1'b1);

    act_period_d = act_period_q;
    act_center_d = act_center_q;
    act_duty_d   = act_duty_q;
    if (commit) begin
      act_period_d = pend_period_q;
      act_center_d = pend_center_q;
      act_duty_d   = pend_duty_q;
    end

    pend_period_d = pend_period_q;
    pend_center_d = pend_center_q;
    pend_duty_d   = pend_duty_q;
    pend_flag_d   = pend_flag_q && !commit;
    if (load) begin
      pend_period_d = period;
      pend_center_d = center;
      pend_duty_d   = duty;
      pend_flag_d   = 1'b1;
    end
  end

  // Registered outputs.
  always_comb begin
    at_start_d     = !en || wrap;
    period_start_d = en && at_start_q;
    load_ack_d     = commit;
    out_d          = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      out_d[i] = en && (cnt_q < act_duty_q[i*W +: W]);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      dir_q          <= 1'b0;
      act_period_q   <= '0;
      act_center_q   <= 1'b0;
      act_duty_q     <= '0;
      pend_period_q  <= '0;
      pend_center_q  <= 1'b0;
      pend_duty_q    <= '0;
      pend_flag_q    <= 1'b0;
      at_start_q     <= 1'b1;
      load_ack_q     <= 1'b0;
      period_start_q <= 1'b0;
      out_q          <= '0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      act_period_q   <= act_period_d;
      act_center_q   <= act_center_d;
      act_duty_q     <= act_duty_d;
      pend_period_q  <= pend_period_d;
      pend_center_q  <= pend_center_d;
      pend_duty_q    <= pend_duty_d;
      pend_flag_q    <= pend_flag_d;
      at_start_q     <= at_start_d;
      load_ack_q     <= load_ack_d;
      period_start_q <= period_start_d;
      out_q          <= out_d;
    end
  end

  assign load_ack     = load_ack_q;
  assign period_start = period_start_q;
  assign out          = out_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: table of steady-state configurations plus directed
// sequences for double buffering, boundary loads, stopped loads and clear.
module tb_pwm_multi;
  localparam int unsigned N_CH = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned PS_W = 8;

  logic              clk = 1'b0;
  logic              clr;
  logic              en;
  logic [PS_W-1:0]   prescale;
  logic [W-1:0]      period;
  logic              center;
  logic [N_CH*W-1:0] duty;
  logic              load;
  logic              load_ack;
  logic              period_start;
  logic [N_CH-1:0]   out;

  int n_checks = 0;
  int n_errors = 0;

  pwm_multi #(.N_CH(N_CH), .W(W), .PS_W(PS_W)) dut (
    .clk         (clk),
    .clr         (clr),
    .en          (en),
    .prescale    (prescale),
    .period      (period),
    .center      (center),
    .duty        (duty),
    .load        (load),
    .load_ack    (load_ack),
    .period_start(period_start),
    .out         (out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic             center;
    logic [7:0]       prescale;
    logic [7:0]       period;
    logic [31:0]      duty;      // {d3,d2,d1,d0}
    int               per_clk;   // period length in clk cycles
    logic [3:0][7:0]  highs;     // high clk cycles per period, per channel
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_clr();
    clr  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    step();
    step();
    clr = 1'b0;
  endtask

  // Wait (bounded) until period_start is seen at a sample point.
  task automatic wait_ps(input string name, output bit found);
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (period_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) check({name, " period_start timeout"}, 0, 1);
  endtask

  initial begin
    bit   found;
    int   acks;
    int   ps_cnt;
    logic ps_at_per;
    int   hi[4];
    int   w_hi[5];
    int   w_ak[5];
    int   w_ps[5];
    int   exp_hi[5];
    int   exp_ak[5];

    // P=9 edge: ch0 off, 3/10, 9/10, always on.
    vecs[0] = '{center: 1'b0, prescale: 8'd0, period: 8'd9,
                duty: {8'd10, 8'd9, 8'd3, 8'd0}, per_clk: 10,
                highs: {8'd10, 8'd9, 8'd3, 8'd0}};
    // P=4, tick every 3 clk: period 15 clk; duty 4 -> 4 ticks, duty 5 > P -> always.
    vecs[1] = '{center: 1'b0, prescale: 8'd2, period: 8'd4,
                duty: {8'd4, 8'd5, 8'd0, 8'd2}, per_clk: 15,
                highs: {8'd12, 8'd15, 8'd0, 8'd6}};
    // Center P=5: cnt 0..5..1, 10 ticks. cnt<2 on 0,1,1 -> 3; duty 6 = P+1 -> always;
    // duty 5 -> all but cnt=5 -> 9.
    vecs[2] = '{center: 1'b1, prescale: 8'd0, period: 8'd5,
                duty: {8'd5, 8'd6, 8'd0, 8'd2}, per_clk: 10,
                highs: {8'd9, 8'd10, 8'd0, 8'd3}};
    // Center P=1, tick every 2 clk: cnt 0,1 -> 4 clk; duty 1 -> cnt 0 only.
    vecs[3] = '{center: 1'b1, prescale: 8'd1, period: 8'd1,
                duty: {8'd0, 8'd0, 8'd2, 8'd1}, per_clk: 4,
                highs: {8'd0, 8'd0, 8'd4, 8'd2}};
    // Center P=0 behaves as edge: cnt stuck at 0, period every clk.
    vecs[4] = '{center: 1'b1, prescale: 8'd0, period: 8'd0,
                duty: {8'd0, 8'd0, 8'd0, 8'd1}, per_clk: 1,
                highs: {8'd0, 8'd0, 8'd0, 8'd1}};

    clr      = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    prescale = '0;
    period   = '0;
    center   = 1'b0;
    duty     = '0;
    repeat (3) step();
    check("reset out", 32'(out), 0);
    check("reset load_ack", 32'(load_ack), 0);
    check("reset period_start", 32'(period_start), 0);
    clr = 1'b0;
    step();

    // ---------------- table-driven steady-state vectors ----------------
    for (int v = 0; v < 5; v++) begin
      do_clr();
      prescale = vecs[v].prescale;
      period   = vecs[v].period;
      center   = vecs[v].center;
      duty     = vecs[v].duty;
      load     = 1'b1;
      step();
      load = 1'b0;
      acks = 0;
      for (int k = 0; k < 3; k++) begin
        step();
        if (load_ack === 1'b1) acks++;
      end
      check($sformatf("vec%0d stopped load_ack count", v), 32'(acks), 1);

      en = 1'b1;
      wait_ps($sformatf("vec%0d", v), found);
      if (found) begin
        ps_cnt    = 0;
        ps_at_per = 1'b0;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int k = 0; k < 2 * vecs[v].per_clk; k++) begin
          if (k > 0) step();
          if (period_start === 1'b1) ps_cnt++;
          if (k == vecs[v].per_clk) ps_at_per = period_start;
          for (int c = 0; c < 4; c++) hi[c] += (out[c] === 1'b1) ? 1 : 0;
        end
        check($sformatf("vec%0d period_start count", v), 32'(ps_cnt), 2);
        check($sformatf("vec%0d period length", v), 32'(ps_at_per), 1);
        for (int c = 0; c < 4; c++) begin
          check($sformatf("vec%0d ch%0d high cycles", v, c), 32'(hi[c]),
                32'(2 * int'(vecs[v].highs[c])));
        end
      end
      en = 1'b0;
    end

    // ---------------- double buffer and boundary load ----------------
    do_clr();
    prescale = 8'd0;
    period   = 8'd9;
    center   = 1'b0;
    duty     = {8'd0, 8'd0, 8'd0, 8'd3};
    load     = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    en = 1'b1;
    wait_ps("dbuf", found);
    if (found) begin
      for (int w = 0; w < 5; w++) begin
        w_hi[w] = 0;
        w_ak[w] = 0;
        w_ps[w] = 0;
      end
      // Window w covers one 10-clk period. Loads at k=3 and k=6 (last wins, one ack at
      // the end of window 0). Load at k=28 lands on the boundary tick: skipped there,
      // committed at the following boundary (ack at end of window 3).
      exp_hi = '{3, 5, 5, 5, 2};
      exp_ak = '{1, 0, 0, 1, 0};
      for (int k = 0; k < 50; k++) begin
        if (k > 0) step();
        w_hi[k / 10] += (out[0] === 1'b1) ? 1 : 0;
        w_ak[k / 10] += (load_ack === 1'b1) ? 1 : 0;
        w_ps[k / 10] += (period_start === 1'b1) ? 1 : 0;
        case (k)
          3:       begin duty = {8'd0, 8'd0, 8'd0, 8'd7}; load = 1'b1; end
          6:       begin duty = {8'd0, 8'd0, 8'd0, 8'd5}; load = 1'b1; end
          28:      begin duty = {8'd0, 8'd0, 8'd0, 8'd2}; load = 1'b1; end
          4, 7, 29: load = 1'b0;
          default: ;
        endcase
      end
      for (int w = 0; w < 5; w++) begin
        check($sformatf("dbuf win%0d ch0 high", w), 32'(w_hi[w]), 32'(exp_hi[w]));
        check($sformatf("dbuf win%0d load_ack", w), 32'(w_ak[w]), 32'(exp_ak[w]));
        check($sformatf("dbuf win%0d period_start", w), 32'(w_ps[w]), 1);
      end
    end

    // ---------------- load while stopped ----------------
    en = 1'b0;
    step();
    step();
    check("stopped out", 32'(out), 0);
    check("stopped period_start", 32'(period_start), 0);
    duty = {8'd0, 8'd0, 8'd0, 8'd4};
    load = 1'b1;
    step();
    load = 1'b0;
    check("stopped ack +1", 32'(load_ack), 0);
    step();
    check("stopped ack +2", 32'(load_ack), 1);
    step();
    check("stopped ack +3", 32'(load_ack), 0);

    // ---------------- clr mid-period with a load pending ----------------
    en = 1'b1;
    wait_ps("clr", found);
    repeat (4) step();
    duty = {8'd9, 8'd9, 8'd9, 8'd9};
    load = 1'b1;
    step();
    load = 1'b0;
    clr  = 1'b1;
    step();
    clr = 1'b0;
    check("clr out", 32'(out), 0);
    check("clr load_ack", 32'(load_ack), 0);
    check("clr period_start", 32'(period_start), 0);
    ps_cnt = 0;
    acks   = 0;
    hi[0]  = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (period_start === 1'b1) ps_cnt++;
      if (load_ack === 1'b1) acks++;
      if (out !== '0) hi[0]++;
    end
    check("post-clr period_start every clk", 32'(ps_cnt), 20);
    check("post-clr no load_ack", 32'(acks), 0);
    check("post-clr out low", 32'(hi[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
